// File: rtl/apple_spawn_ctrl_pkg.sv
// Shared grid geometry and FSM encoding for the apple spawner.
// The body and render logic import the same defaults.
package apple_spawn_ctrl_pkg;

    localparam int DEF_GRID_W    = 40;
    localparam int DEF_GRID_H    = 30;
    localparam int DEF_XW        = 6;
    localparam int DEF_YW        = 5;
    localparam int DEF_MAX_TRIES = 8;
    localparam int CELLS         = DEF_GRID_W * DEF_GRID_H;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        QUERY,
        SCAN,
        PLACE,
        FAIL
    } state_t;

endpackage

// File: rtl/apple_spawn_ctrl_if.sv
// Spawn request, random source, occupancy query and apple result bundle.
// The master side is the spawner; the slave side is the game/body logic.
interface apple_spawn_ctrl_if
    import apple_spawn_ctrl_pkg::*;
#(
    parameter int XW = DEF_XW,
    parameter int YW = DEF_YW
);

    logic          spawn_req;
    logic [XW-1:0] rand_x;
    logic [YW-1:0] rand_y;
    logic          rand_adv;
    logic          occ_req;
    logic [XW-1:0] occ_x;
    logic [YW-1:0] occ_y;
    logic          occ_ack;
    logic          occ_hit;
    logic [XW-1:0] apple_x;
    logic [YW-1:0] apple_y;
    logic          apple_valid;
    logic          busy;
    logic          spawn_done;
    logic          spawn_fail;

    modport master (
        input  spawn_req, rand_x, rand_y, occ_ack, occ_hit,
        output rand_adv, occ_req, occ_x, occ_y,
        output apple_x, apple_y, apple_valid,
        output busy, spawn_done, spawn_fail
    );

    modport slave (
        output spawn_req, rand_x, rand_y, occ_ack, occ_hit,
        input  rand_adv, occ_req, occ_x, occ_y,
        input  apple_x, apple_y, apple_valid,
        input  busy, spawn_done, spawn_fail
    );

endinterface

// File: rtl/apple_spawn_ctrl_grid_cursor.sv
// Candidate cell cursor: folded random load, raster step with wrap,
// and the count of cells visited by the linear scan.
module apple_spawn_ctrl_grid_cursor #(
    parameter int GRID_W = 40,
    parameter int GRID_H = 30,
    parameter int XW     = 6,
    parameter int YW     = 5,
    parameter int CW     = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic          clr,
    input  logic          inc,
    input  logic [XW-1:0] rx,
    input  logic [YW-1:0] ry,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic [CW-1:0] cnt
);

    logic [XW-1:0] fx;
    logic [YW-1:0] fy;

    // Sources are at most twice the grid size, so one subtraction folds.
    assign fx = (32'(rx) >= GRID_W) ? rx - XW'(GRID_W) : rx;
    assign fy = (32'(ry) >= GRID_H) ? ry - YW'(GRID_H) : ry;

    always_ff @(posedge clock) begin
        if (reset) begin
            cx  <= '0;
            cy  <= '0;
            cnt <= '0;
        end else begin
            if (load) begin
                cx <= fx;
                cy <= fy;
            end else if (step) begin
                if (cx == XW'(GRID_W - 1)) begin
                    cx <= '0;
                    cy <= (cy == YW'(GRID_H - 1)) ? '0 : cy + YW'(1);
                end else begin
                    cx <= cx + XW'(1);
                end
            end
            if (clr) begin
                cnt <= '0;
            end else if (inc) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple placement FSM: random tries against the occupancy map,
// then a linear scan fallback; owns the apple position register.
module apple_spawn_ctrl
    import apple_spawn_ctrl_pkg::*;
#(
    parameter int GRID_W    = DEF_GRID_W,
    parameter int GRID_H    = DEF_GRID_H,
    parameter int XW        = DEF_XW,
    parameter int YW        = DEF_YW,
    parameter int MAX_TRIES = DEF_MAX_TRIES
) (
    input  logic                 clock,
    input  logic                 reset,
    apple_spawn_ctrl_if.master   bus
);

    localparam int NCELLS = GRID_W * GRID_H;
    localparam int CW     = $clog2(NCELLS) + 1;
    localparam int TW     = $clog2(MAX_TRIES + 1);

    state_t        state, state_n;
    logic [TW-1:0] try_cnt, try_n;
    logic          cur_load, cur_step, cur_clr, cur_inc;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [CW-1:0] cnt;
    logic [XW-1:0] apple_x;
    logic [YW-1:0] apple_y;
    logic          apple_valid;

    apple_spawn_ctrl_grid_cursor #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW),
        .CW     (CW)
    ) grid_cursor (
        .clock (clock),
        .reset (reset),
        .load  (cur_load),
        .step  (cur_step),
        .clr   (cur_clr),
        .inc   (cur_inc),
        .rx    (bus.rand_x),
        .ry    (bus.rand_y),
        .cx    (cx),
        .cy    (cy),
        .cnt   (cnt)
    );

    always_comb begin
        state_n  = state;
        try_n    = try_cnt;
        cur_load = 1'b0;
        cur_step = 1'b0;
        cur_clr  = 1'b0;
        cur_inc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.spawn_req) begin
                    state_n = SAMPLE;
                    try_n   = '0;
                end
            end
            SAMPLE: begin
                cur_load = 1'b1;
                state_n  = QUERY;
            end
            QUERY: begin
                if (bus.occ_ack) begin
                    if (!bus.occ_hit) begin
                        state_n = PLACE;
                    end else begin
                        try_n = try_cnt + TW'(1);
                        if (32'(try_n) < MAX_TRIES) begin
                            state_n = SAMPLE;
                        end else begin
                            // Scan starts on the cell after the last candidate.
                            state_n  = SCAN;
                            cur_step = 1'b1;
                            cur_clr  = 1'b1;
                        end
                    end
                end
            end
            SCAN: begin
                if (bus.occ_ack) begin
                    if (!bus.occ_hit) begin
                        state_n = PLACE;
                    end else if (cnt == CW'(NCELLS - 1)) begin
                        state_n = FAIL;
                    end else begin
                        cur_step = 1'b1;
                        cur_inc  = 1'b1;
                    end
                end
            end
            PLACE:   state_n = IDLE;
            FAIL:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            try_cnt     <= '0;
            apple_x     <= '0;
            apple_y     <= '0;
            apple_valid <= 1'b0;
        end else begin
            state   <= state_n;
            try_cnt <= try_n;
            if (state == IDLE && bus.spawn_req) begin
                apple_valid <= 1'b0;
            end
            // Loaded on entry so the position is visible with spawn_done.
            if (state_n == PLACE) begin
                apple_x     <= cx;
                apple_y     <= cy;
                apple_valid <= 1'b1;
            end
        end
    end

    assign bus.occ_req     = (state == QUERY) || (state == SCAN);
    assign bus.occ_x       = cx;
    assign bus.occ_y       = cy;
    assign bus.rand_adv    = (state == SAMPLE);
    assign bus.spawn_done  = (state == PLACE);
    assign bus.spawn_fail  = (state == FAIL);
    assign bus.busy        = (state != IDLE);
    assign bus.apple_x     = apple_x;
    assign bus.apple_y     = apple_y;
    assign bus.apple_valid = apple_valid;

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Directed bench for apple_spawn_ctrl with an occupancy responder
// and a scoreboard of expected spawn results.
module tb_apple_spawn_ctrl;

    typedef struct {
        bit       fail;
        bit [5:0] x;
        bit [4:0] y;
        int       lat;
    } exp_t;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   ack_delay = 0;
    bit   all_hit = 0;
    bit   occ [0:1199];
    int   wcnt = 0;
    int   adv_cnt = 0;
    int   q_cnt = 0;
    int   done_cnt = 0;
    int   fail_cnt = 0;
    logic [10:0] qlog [$];
    exp_t sb [$];

    apple_spawn_ctrl_if #(.XW(6), .YW(5)) bus ();

    apple_spawn_ctrl #(
        .GRID_W    (40),
        .GRID_H    (30),
        .XW        (6),
        .YW        (5),
        .MAX_TRIES (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus.occ_ack = bus.occ_req && (wcnt >= ack_delay);
    assign bus.occ_hit = bus.occ_ack &&
        (all_hit || occ[int'(bus.occ_y) * 40 + int'(bus.occ_x)]);

    always @(posedge clock) begin
        if (!bus.occ_req || bus.occ_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (bus.rand_adv) adv_cnt <= adv_cnt + 1;
        if (bus.spawn_done) done_cnt <= done_cnt + 1;
        if (bus.spawn_fail) fail_cnt <= fail_cnt + 1;
        if (bus.occ_req && bus.occ_ack) begin
            q_cnt <= q_cnt + 1;
            qlog.push_back({bus.occ_x, bus.occ_y});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_occ();
        for (int i = 0; i < 1200; i++) occ[i] = 1'b0;
    endtask

    task automatic pulse_spawn();
        bus.spawn_req = 1'b1;
        @(negedge clock);
        bus.spawn_req = 1'b0;
    endtask

    task automatic wait_result(input int start);
        int   lat;
        exp_t e;
        lat = start;
        while (!bus.spawn_done && !bus.spawn_fail && lat < 3000) begin
            @(negedge clock);
            lat++;
        end
        check("finish", 32'(bus.spawn_done | bus.spawn_fail), 1);
        check("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("fail_flag", 32'(bus.spawn_fail), 32'(e.fail));
            check("apple_x", 32'(bus.apple_x), 32'(e.x));
            check("apple_y", 32'(bus.apple_y), 32'(e.y));
            check("apple_valid", 32'(bus.apple_valid), 32'(!e.fail));
            check("latency", lat, e.lat);
        end
    endtask

    initial begin
        int a0, q0, d0, f0;
        reset = 1'b1;
        bus.spawn_req = 1'b0;
        bus.rand_x = '0;
        bus.rand_y = '0;
        clear_occ();
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_apple_x", 32'(bus.apple_x), 0);
        check("rst_apple_y", 32'(bus.apple_y), 0);
        check("rst_valid", 32'(bus.apple_valid), 0);
        check("rst_occ_req", 32'(bus.occ_req), 0);
        check("rst_adv", 32'(bus.rand_adv), 0);
        check("rst_done", 32'(bus.spawn_done), 0);
        check("rst_fail", 32'(bus.spawn_fail), 0);
        reset = 1'b0;
        repeat (6) @(negedge clock);

        // Free board, immediate ack.
        bus.rand_x = 6'd5;
        bus.rand_y = 5'd7;
        a0 = adv_cnt; q0 = q_cnt;
        sb.push_back('{fail: 0, x: 5, y: 7, lat: 3});
        pulse_spawn();
        wait_result(1);
        check("t1_adv", adv_cnt - a0, 1);
        check("t1_queries", q_cnt - q0, 1);
        @(negedge clock);

        // Out-of-range sources fold onto the grid.
        bus.rand_x = 6'd45;
        bus.rand_y = 5'd31;
        sb.push_back('{fail: 0, x: 5, y: 1, lat: 3});
        pulse_spawn();
        wait_result(1);
        @(negedge clock);

        // First candidate occupied, second free.
        occ[8 * 40 + 7] = 1'b1;
        bus.rand_x = 6'd7;
        bus.rand_y = 5'd8;
        a0 = adv_cnt;
        sb.push_back('{fail: 0, x: 3, y: 3, lat: 5});
        pulse_spawn();
        @(negedge clock);
        bus.rand_x = 6'd3;
        bus.rand_y = 5'd3;
        wait_result(2);
        check("t3_adv", adv_cnt - a0, 2);
        @(negedge clock);

        // All random tries hit, scan finds the second cell after.
        clear_occ();
        occ[29 * 40 + 10] = 1'b1;
        occ[29 * 40 + 11] = 1'b1;
        bus.rand_x = 6'd10;
        bus.rand_y = 5'd29;
        a0 = adv_cnt; q0 = q_cnt;
        sb.push_back('{fail: 0, x: 12, y: 29, lat: 19});
        pulse_spawn();
        wait_result(1);
        check("t4_adv", adv_cnt - a0, 8);
        check("t4_queries", q_cnt - q0, 10);
        if (qlog.size() >= q0 + 10) begin
            check("t4_scan0", 32'(qlog[q0 + 8]), 32'({6'd11, 5'd29}));
            check("t4_scan1", 32'(qlog[q0 + 9]), 32'({6'd12, 5'd29}));
        end
        @(negedge clock);

        // Scan wraps from the last cell to the origin.
        clear_occ();
        occ[29 * 40 + 39] = 1'b1;
        bus.rand_x = 6'd39;
        bus.rand_y = 5'd29;
        sb.push_back('{fail: 0, x: 0, y: 0, lat: 18});
        pulse_spawn();
        wait_result(1);
        @(negedge clock);

        // Full board: every query hits.
        all_hit = 1'b1;
        q0 = q_cnt;
        sb.push_back('{fail: 1, x: 0, y: 0, lat: 1217});
        pulse_spawn();
        wait_result(1);
        check("t6_queries", q_cnt - q0, 8 + 1200);
        @(negedge clock);
        check("t6_busy_after", 32'(bus.busy), 0);
        all_hit = 1'b0;
        clear_occ();

        // Delayed ack: query held stable, spawn_req while busy ignored.
        ack_delay = 4;
        bus.rand_x = 6'd20;
        bus.rand_y = 5'd10;
        d0 = done_cnt; a0 = adv_cnt;
        sb.push_back('{fail: 0, x: 20, y: 10, lat: 7});
        pulse_spawn();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t7_req_hold", 32'(bus.occ_req), 1);
            check("t7_x_hold", 32'(bus.occ_x), 20);
            check("t7_y_hold", 32'(bus.occ_y), 10);
            bus.spawn_req = (i == 1);
        end
        bus.spawn_req = 1'b0;
        wait_result(5);
        repeat (5) @(negedge clock);
        check("t7_busy", 32'(bus.busy), 0);
        check("t7_done_cnt", done_cnt - d0, 1);
        check("t7_adv", adv_cnt - a0, 1);

        // Reset during QUERY aborts silently.
        d0 = done_cnt; f0 = fail_cnt;
        pulse_spawn();
        @(negedge clock);
        check("t8_in_query", 32'(bus.occ_req), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t8_busy", 32'(bus.busy), 0);
        check("t8_occ_req", 32'(bus.occ_req), 0);
        check("t8_valid", 32'(bus.apple_valid), 0);
        check("t8_apple_x", 32'(bus.apple_x), 0);
        repeat (10) @(negedge clock);
        check("t8_no_done", done_cnt - d0, 0);
        check("t8_no_fail", fail_cnt - f0, 0);

        // Reset wins over a simultaneous spawn_req.
        reset = 1'b1;
        bus.spawn_req = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.spawn_req = 1'b0;
        check("t9_busy0", 32'(bus.busy), 0);
        @(negedge clock);
        check("t9_busy1", 32'(bus.busy), 0);
        check("t9_adv", 32'(bus.rand_adv), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
